rominit_xfer: RTL and testbench
===============================

// Module: rominit_xfer
// PURPOSE
//  Parametrised download manager: routes HPS ioctl bytes into N ROM regions
//  via a region table. Decouples the ioctl stream from slow targets with a
//  small FIFO and a VALID/READY handshake, and back-pressures through
//  IOCTL_WAIT. Flags stray or overflowing writes and pulses DONE when the
//  load is fully drained. Sits between hps_io and the core's ROM/RAM init ports.
// PARAMETERS
//  NUM_REGIONS  4     number of ROM regions; SEL is one-hot of this width
//  ADDR_W       17    width of ROMINIT_ADDR (region-local byte address)
//  FIFO_DEPTH   4     FIFO entries; power of 2, >=2
//  REGION_MENU  {6'd1,6'd0,6'd0,6'd0}  IOCTL_INDEX[5:0] match per region (region0 in LSBs)
//  REGION_BASE  {27'h0,27'h1400,27'h1000,27'h0}  ioctl base address per region
//  REGION_LOG2  {5'd17,5'd10,5'd10,5'd12}  region size = 2**LOG2 bytes, <=ADDR_W
// PORTS
//  CLK_SYS         in   1            system clock
//  RESET_N         in   1            asynchronous active-low reset
//  IOCTL_DOWNLOAD  in   1            download in progress (level)
//  IOCTL_INDEX     in   16           [5:0] menu sub-index
//  IOCTL_WR        in   1            byte strobe, one cycle per byte
//  IOCTL_ADDR      in   27           byte address within file
//  IOCTL_DOUT      in   8            byte data
//  IOCTL_WAIT      out  1            back-pressure to hps_io
//  ROMINIT_ACTIVE  out  1            high in LOAD and DRAIN
//  ROMINIT_SEL     out  NUM_REGIONS  one-hot target region of head entry
//  ROMINIT_ADDR    out  ADDR_W       region-local address of head entry
//  ROMINIT_DATA    out  8            data of head entry
//  ROMINIT_VALID   out  1            head entry valid (FIFO not empty)
//  ROMINIT_READY   in   1            target accepts head this cycle
//  ROMINIT_DONE    out  1            one-cycle pulse: load complete, FIFO empty
//  ROMINIT_ERR     out  1            sticky: stray/dropped write this load
// BEHAVIOUR
//  - Reset: state IDLE, FIFO empty. All outputs 0. Reset mid-load flushes
//    the FIFO and loses queued bytes.
//  - FSM IDLE->LOAD when DOWNLOAD=1. On entry: latch INDEX[5:0], clear ERR.
//    LOAD->DRAIN when DOWNLOAD=0. DRAIN->DONE when FIFO empty.
//    DONE (1 cycle, DONE=1)->IDLE. WR ignored outside LOAD.
//  - Decode (LOAD, WR=1): region r hits iff menu==REGION_MENU[r] and
//    BASE[r] <= ADDR < BASE[r]+2**LOG2[r]. Lowest r wins on overlap.
//    Local addr = (ADDR-BASE[r]) zero-extended to ADDR_W. Hit pushes
//    {r,addr,data}; miss drops the byte and sets ERR.
//  - FIFO: VALID = !empty; SEL/ADDR/DATA come from head and are stable while
//    VALID & !READY. Pop on VALID & READY. Push and pop in the same cycle are
//    both honoured, including when full.
//  - WAIT registered: next-cycle WAIT = (occupancy after this cycle's
//    push/pop >= FIFO_DEPTH-1). The slot kept in reserve absorbs the single
//    write that may land in the cycle WAIT rises.
//  - Write when full with no pop: dropped, ERR set. FIFO is never corrupted.
//  - Occupancy counter is $clog2(FIFO_DEPTH)+1 bits; pointers wrap modulo depth.
//  - DOWNLOAD re-asserted during DRAIN: finish DRAIN, then DONE, then IDLE,
//    then LOAD on the following cycle.
//  - Zero-latency path: a push into an empty FIFO gives VALID on the next cycle.
// STRUCTURE
//  - rominit_pkg: state enum (IDLE, LOAD, DRAIN, DONE); fifo entry struct
//    {sel idx, addr, data}; default region table constants.
//  - One sub-module rominit_fifo (param WIDTH, DEPTH): regs, wrap pointers,
//    count, full/empty. Decode and FSM stay in rominit_xfer.
// TESTING
//  1. Defaults, menu 0, bytes 0x0000-0x17FF, READY=1 -> SEL 0001/0010/0100
//     in order; addr 0x000-0xFFF, then 0x000-0x3FF twice; ERR=0; DONE pulses once.
//  2. Menu 1, 128 KiB, READY=1 -> SEL=1000, ADDR=IOCTL_ADDR[16:0]; the final
//     byte reaches the target before DONE.
//  3. READY=0 with WR every cycle -> WAIT rises by occupancy 3; no drops;
//     ERR=0; release READY and all bytes emerge in order.
//  4. Menu 0, ADDR=0x1800 -> no VALID, ERR=1 held until the next load start.
//  5. WR while full, source ignoring WAIT -> byte dropped, ERR=1, queued
//     data intact.
//  6. RESET_N low mid-load with 3 queued -> VALID/WAIT/ACTIVE=0 async;
//     after release, IDLE and empty.

Source files
------------

// File: rtl/rominit_pkg.sv
// rominit_pkg: shared types and default region table for the ROM download manager
package rominit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Sized for the widest legal configuration; unused upper bits are dropped at the outputs
    typedef struct packed {
        logic [7:0]  idx;
        logic [26:0] addr;
        logic [7:0]  data;
    } entry_t;

    localparam int DEF_NUM_REGIONS = 4;
    localparam int DEF_ADDR_W      = 17;
    localparam int DEF_FIFO_DEPTH  = 4;

    localparam logic [23:0]  DEF_REGION_MENU = {6'd1, 6'd0, 6'd0, 6'd0};
    localparam logic [107:0] DEF_REGION_BASE = {27'h0, 27'h1400, 27'h1000, 27'h0};
    localparam logic [19:0]  DEF_REGION_LOG2 = {5'd17, 5'd10, 5'd10, 5'd12};

endpackage

// File: rtl/rominit_xfer_fifo.sv
// rominit_fifo: small power-of-two FIFO with wrapping pointers and occupancy count
module rominit_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_din,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_full  = r_count == CNT_W'(DEPTH);
    assign o_empty = r_count == '0;
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rd];

    // Storage; a push into a full FIFO overwrites only the slot being popped this cycle
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr] <= i_din;
    end

    // Pointers wrap naturally at the power-of-two depth
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            r_wr    <= r_wr + PTR_W'(w_push);
            r_rd    <= r_rd + PTR_W'(w_pop);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

endmodule

// File: rtl/rominit_xfer.sv
// rominit_xfer: routes ioctl download bytes into ROM regions through a handshake FIFO
module rominit_xfer
    import rominit_pkg::*;
#(
    parameter int                          NUM_REGIONS = DEF_NUM_REGIONS,
    parameter int                          ADDR_W      = DEF_ADDR_W,
    parameter int                          FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter logic [6*NUM_REGIONS-1:0]    REGION_MENU = DEF_REGION_MENU,
    parameter logic [27*NUM_REGIONS-1:0]   REGION_BASE = DEF_REGION_BASE,
    parameter logic [5*NUM_REGIONS-1:0]    REGION_LOG2 = DEF_REGION_LOG2
) (
    input  logic                   i_clk_sys,
    input  logic                   i_reset_n,
    input  logic                   i_ioctl_download,
    input  logic [15:0]            i_ioctl_index,
    input  logic                   i_ioctl_wr,
    input  logic [26:0]            i_ioctl_addr,
    input  logic [7:0]             i_ioctl_dout,
    output logic                   o_ioctl_wait,
    output logic                   o_rominit_active,
    output logic [NUM_REGIONS-1:0] o_rominit_sel,
    output logic [ADDR_W-1:0]      o_rominit_addr,
    output logic [7:0]             o_rominit_data,
    output logic                   o_rominit_valid,
    input  logic                   i_rominit_ready,
    output logic                   o_rominit_done,
    output logic                   o_rominit_err
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t           r_state;
    logic [5:0]       r_menu;
    logic             r_err;
    logic             r_wait;
    logic             r_done;
    logic             r_active;

    logic             w_hit;
    logic [7:0]       w_idx;
    logic [26:0]      w_local;
    logic [27:0]      w_diff;
    logic             w_wr_load;
    logic             w_push;
    logic             w_pop;
    logic             w_drop;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] w_occ_next;
    entry_t           w_din;
    entry_t           w_head;
    logic             w_unused;

    // Region decode: scan high to low so the lowest matching region wins
    always_comb begin
        w_hit   = 1'b0;
        w_idx   = '0;
        w_local = '0;
        w_diff  = '0;
        for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
            w_diff = {1'b0, i_ioctl_addr} - {1'b0, REGION_BASE[27*r +: 27]};
            if (r_menu == REGION_MENU[6*r +: 6] && !w_diff[27] &&
                (w_diff >> REGION_LOG2[5*r +: 5]) == 28'd0) begin
                w_hit   = 1'b1;
                w_idx   = 8'(r);
                w_local = w_diff[26:0];
            end
        end
    end

    assign w_wr_load  = (r_state == ST_LOAD) && i_ioctl_wr;
    assign w_pop      = !w_empty && i_rominit_ready;
    assign w_push     = w_wr_load && w_hit && (!w_full || w_pop);
    assign w_drop     = w_wr_load && !w_push;
    assign w_occ_next = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_din      = '{idx: w_idx, addr: w_local, data: i_ioctl_dout};

    rominit_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk_sys),
        .i_rst_n (i_reset_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_din),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Load sequencer: latch the menu on entry, hold ERR sticky until the next load
    always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state  <= ST_IDLE;
            r_menu   <= '0;
            r_err    <= 1'b0;
            r_done   <= 1'b0;
            r_active <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: if (i_ioctl_download) begin
                    r_state  <= ST_LOAD;
                    r_menu   <= i_ioctl_index[5:0];
                    r_err    <= 1'b0;
                    r_active <= 1'b1;
                end
                ST_LOAD: begin
                    if (w_drop) r_err <= 1'b1;
                    if (!i_ioctl_download) r_state <= ST_DRAIN;
                end
                ST_DRAIN: if (w_empty) begin
                    r_state  <= ST_DONE;
                    r_active <= 1'b0;
                    r_done   <= 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // WAIT anticipates occupancy so one spare slot absorbs the write in flight when it rises
    always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
        if (!i_reset_n) r_wait <= 1'b0;
        else            r_wait <= w_occ_next >= CNT_W'(FIFO_DEPTH - 1);
    end

    assign o_ioctl_wait     = r_wait;
    assign o_rominit_active = r_active;
    assign o_rominit_done   = r_done;
    assign o_rominit_err    = r_err;
    assign o_rominit_valid  = !w_empty;
    assign o_rominit_sel    = w_empty ? '0 : NUM_REGIONS'(1) << w_head.idx;
    assign o_rominit_addr   = w_empty ? '0 : w_head.addr[ADDR_W-1:0];
    assign o_rominit_data   = w_empty ? '0 : w_head.data;
    assign w_unused         = &{1'b0, i_ioctl_index, w_head};

endmodule

// File: tb/tb_rominit_xfer.sv
// tb_rominit_xfer: directed stimulus with a queue-based reference model and per-cycle compare
module tb_rominit_xfer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        dl = 1'b0;
    logic        wr = 1'b0;
    logic        ready = 1'b0;
    logic [15:0] idx = '0;
    logic [26:0] addr = '0;
    logic [7:0]  dout = '0;

    logic        o_wait, o_active, o_valid, o_done, o_err;
    logic [3:0]  o_sel;
    logic [16:0] o_addr;
    logic [7:0]  o_data;

    always #5 clk = ~clk;

    rominit_xfer dut (
        .i_clk_sys        (clk),
        .i_reset_n        (rst_n),
        .i_ioctl_download (dl),
        .i_ioctl_index    (idx),
        .i_ioctl_wr       (wr),
        .i_ioctl_addr     (addr),
        .i_ioctl_dout     (dout),
        .o_ioctl_wait     (o_wait),
        .o_rominit_active (o_active),
        .o_rominit_sel    (o_sel),
        .o_rominit_addr   (o_addr),
        .o_rominit_data   (o_data),
        .o_rominit_valid  (o_valid),
        .i_rominit_ready  (ready),
        .o_rominit_done   (o_done),
        .o_rominit_err    (o_err)
    );

    int n_total = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: region table, queue of pending {sel,addr,data}, load phase
    int          m_base[4] = '{0, 'h1000, 'h1400, 0};
    int          m_log2[4] = '{12, 10, 10, 17};
    int          m_mtab[4] = '{0, 0, 0, 1};
    logic [28:0] mq[$];
    int          m_ph = 0;
    int          m_pre = 0;
    int          m_hit = -1;
    bit          m_pop = 0;
    bit          m_wait = 0;
    bit          m_err = 0;
    bit          m_done = 0;
    int          m_menu = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_ph = 0; m_wait = 0; m_err = 0; m_done = 0; m_menu = 0;
        end else begin
            m_pre = mq.size();
            m_pop = (m_pre > 0) && ready;
            m_hit = -1;
            if (m_ph == 1 && wr) begin
                for (int r = 0; r < 4; r++)
                    if (m_hit < 0 && m_menu == m_mtab[r] && int'(addr) >= m_base[r] &&
                        int'(addr) < m_base[r] + (1 << m_log2[r])) m_hit = r;
                if (m_hit < 0 || (m_pre == 4 && !m_pop)) m_err = 1;
            end
            if (m_pop) void'(mq.pop_front());
            if (m_hit >= 0 && (m_pre < 4 || m_pop))
                mq.push_back({4'(1 << m_hit), 17'(int'(addr) - m_base[m_hit]), dout});
            m_done = 0;
            case (m_ph)
                0: if (dl) begin m_ph = 1; m_menu = int'(idx[5:0]); m_err = 0; end
                1: if (!dl) m_ph = 2;
                2: if (m_pre == 0) begin m_ph = 3; m_done = 1; end
                default: m_ph = 0;
            endcase
            m_wait = mq.size() >= 3;
        end
    end

    // Delivered-entry log captured on the accepting edge
    logic [28:0] dl_q[$];
    int          n_done = 0;
    int          dl_at_done = 0;

    always @(posedge clk) begin
        if (rst_n && o_valid && ready) dl_q.push_back({o_sel, o_addr, o_data});
    end

    always @(negedge clk) begin
        logic [28:0] h;
        h = (mq.size() > 0) ? mq[0] : 29'd0;
        chk("valid", o_valid, mq.size() > 0);
        chk("sel", o_sel, h[28:25]);
        chk("addr", o_addr, h[24:8]);
        chk("data", o_data, h[7:0]);
        chk("wait", o_wait, m_wait);
        chk("active", o_active, m_ph == 1 || m_ph == 2);
        chk("done", o_done, m_done);
        chk("err", o_err, m_err);
        if (o_done) begin n_done++; dl_at_done = dl_q.size(); end
    end

    task automatic tick();
        @(negedge clk); wr = 1'b0;
    endtask

    task automatic wbyte(input int a, input int d);
        @(negedge clk); wr = 1'b1; addr = 27'(a); dout = 8'(d);
    endtask

    task automatic start_load(input int m);
        @(negedge clk); wr = 1'b0; idx = 16'(m); dl = 1'b1;
        @(negedge clk);
        dl_q.delete(); n_done = 0; dl_at_done = 0;
    endtask

    task automatic finish_load(input int budget);
        int c;
        @(negedge clk); wr = 1'b0; dl = 1'b0;
        c = 0;
        while (!o_done && c < budget) begin @(negedge clk); c++; end
        chk("done_seen", o_done, 1);
        @(negedge clk);
    endtask

    task automatic chk_dl(input string name, input int i, input int s, input int a, input int d);
        logic [28:0] e;
        e = (i < dl_q.size()) ? dl_q[i] : 29'h1FFFFFFF;
        chk(name, e, {4'(s), 17'(a), 8'(d)});
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", o_valid, 0);
        chk("rst_sel", o_sel, 0);
        chk("rst_wait", o_wait, 0);
        chk("rst_active", o_active, 0);
        chk("rst_done", o_done, 0);
        chk("rst_err", o_err, 0);
        #2 rst_n = 1'b1;
        tick();

        // Menu 0 sweep across the three small regions
        ready = 1'b1;
        start_load(0);
        for (int a = 0; a < 'h1800; a++) wbyte(a, (a & 'hFF) ^ 'h5A);
        finish_load(100);
        chk("t1_count", dl_q.size(), 'h1800);
        chk_dl("t1_first", 0, 1, 0, 'h5A);
        chk_dl("t1_r0_last", 'hFFF, 1, 'hFFF, 'hA5);
        chk_dl("t1_r1_first", 'h1000, 2, 0, 'h5A);
        chk_dl("t1_r1_last", 'h13FF, 2, 'h3FF, 'hA5);
        chk_dl("t1_r2_first", 'h1400, 4, 0, 'h5A);
        chk_dl("t1_r2_last", 'h17FF, 4, 'h3FF, 'hA5);
        chk("t1_err", o_err, 0);
        chk("t1_ndone", n_done, 1);

        // Menu 1 into the 128 KiB region, sampled addresses
        start_load(1);
        wbyte(0, 'h11); wbyte(1, 'h22); wbyte('hFFFF, 'h33); wbyte('h10000, 'h44); wbyte('h1FFFF, 'h55);
        finish_load(100);
        chk_dl("t2_first", 0, 8, 0, 'h11);
        chk_dl("t2_mid", 2, 8, 'hFFFF, 'h33);
        chk_dl("t2_last", 4, 8, 'h1FFFF, 'h55);
        chk("t2_before_done", dl_at_done, 5);
        chk("t2_err", o_err, 0);

        // Stalled target: WAIT rises at occupancy 3, reserve slot takes the 4th
        ready = 1'b0;
        start_load(0);
        wbyte('h20, 'hC0); wbyte('h21, 'hC1);
        wbyte('h22, 'hC2);
        chk("t3_wait_occ2", o_wait, 0);
        wbyte('h23, 'hC3);
        chk("t3_wait_occ3", o_wait, 1);
        tick();
        chk("t3_wait_occ4", o_wait, 1);
        chk("t3_err", o_err, 0);
        chk("t3_head", o_data, 'hC0);
        ready = 1'b1;
        finish_load(50);
        chk("t3_count", dl_q.size(), 4);
        chk_dl("t3_first", 0, 1, 'h20, 'hC0);
        chk_dl("t3_last", 3, 1, 'h23, 'hC3);

        // Stray address: no output, ERR sticky past DONE
        start_load(0);
        wbyte('h1800, 'h77);
        tick(); tick();
        chk("t4_valid", o_valid, 0);
        chk("t4_err", o_err, 1);
        finish_load(50);
        tick();
        chk("t4_err_idle", o_err, 1);
        chk("t4_count", dl_q.size(), 0);

        // Overflow: source ignores WAIT, fifth byte dropped
        ready = 1'b0;
        start_load(0);
        chk("t5_err_cleared", o_err, 0);
        for (int i = 0; i < 5; i++) wbyte('h30 + i, 'hA0 + i);
        tick();
        chk("t5_err", o_err, 1);
        chk("t5_head", o_data, 'hA0);
        ready = 1'b1;
        finish_load(50);
        chk("t5_count", dl_q.size(), 4);
        chk_dl("t5_first", 0, 1, 'h30, 'hA0);
        chk_dl("t5_last", 3, 1, 'h33, 'hA3);

        // Asynchronous reset with entries queued
        ready = 1'b0;
        start_load(0);
        wbyte('h40, 1); wbyte('h41, 2); wbyte('h42, 3);
        tick();
        chk("t6_pre_valid", o_valid, 1);
        chk("t6_pre_wait", o_wait, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_valid", o_valid, 0);
        chk("t6_async_wait", o_wait, 0);
        chk("t6_async_active", o_active, 0);
        dl = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        tick(); tick();
        chk("t6_idle_active", o_active, 0);
        chk("t6_idle_valid", o_valid, 0);
        chk("t6_idle_done", o_done, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", n_bad);
        $fatal(1);
    end

endmodule
